// File: rtl/i2c_slave_mem_pkg.sv
// Shared definitions for the I2C memory target: bus constants, FSM states,
// acknowledge sub-phases and the device-address match helper.
package i2c_slave_mem_pkg;

   localparam logic [6:0] DEV_ADDR_DEF    = 7'h50;
   localparam int         MEM_DEPTH_DEF   = 256;
   localparam int         SYNC_STAGES_DEF = 2;

   // Level seen on SDA during the 9th clock when the receiver declines the byte.
   localparam logic I2C_NACK = 1'b1;
   // Position of the R/W flag inside the address byte.
   localparam int   RW_BIT   = 0;

   typedef enum logic [3:0] {
      ST_IDLE,
      ST_DEV_ADDR,
      ST_DEV_ACK,
      ST_WORD_ADDR,
      ST_WORD_ACK,
      ST_WR_DATA,
      ST_WR_ACK,
      ST_READ_DATA,
      ST_READ_ACK
   } state_e;

   // Sub-phase inside the acknowledge states, advanced by SCL edges.
   typedef enum logic [1:0] {
      AP_PRE,   // waiting for the SCL fall that opens the 9th bit
      AP_MID,   // 9th bit in progress
      AP_POST   // read path: initiator ACKed, next byte loads on the coming fall
   } ack_phase_e;

   function automatic logic addr_match(input logic [7:0] addr_byte, input logic [6:0] dev);
      return addr_byte[7:1] == dev;
   endfunction

endpackage

// File: rtl/i2c_slave_mem_bus_sync.sv
// Pad synchroniser for SCL/SDA plus edge, START and STOP detection pulses.
module i2c_slave_mem_bus_sync #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic scl_i,
   input  logic sda_i,
   output logic sda_o,
   output logic scl_rise_o,
   output logic scl_fall_o,
   output logic start_det_o,
   output logic stop_det_o
);

   logic [SYNC_STAGES-1:0] scl_sync_q, scl_sync_d;
   logic [SYNC_STAGES-1:0] sda_sync_q, sda_sync_d;
   logic                   scl_prev_q, sda_prev_q;
   logic                   scl_s, sda_s;

   genvar gi;
   generate
      for (gi = 0; gi < SYNC_STAGES; gi++) begin : g_stage
         if (gi == 0) begin : g_first
            assign scl_sync_d[gi] = scl_i;
            assign sda_sync_d[gi] = sda_i;
         end else begin : g_next
            assign scl_sync_d[gi] = scl_sync_q[gi-1];
            assign sda_sync_d[gi] = sda_sync_q[gi-1];
         end
      end
   endgenerate

   assign scl_s = scl_sync_q[SYNC_STAGES-1];
   assign sda_s = sda_sync_q[SYNC_STAGES-1];

   // Synchroniser chain and one-cycle history; resets to the idle-bus level (both high).
   always_ff @(posedge clk) begin
      if (rst) begin
         scl_sync_q <= '1;
         sda_sync_q <= '1;
         scl_prev_q <= 1'b1;
         sda_prev_q <= 1'b1;
      end else begin
         scl_sync_q <= scl_sync_d;
         sda_sync_q <= sda_sync_d;
         scl_prev_q <= scl_s;
         sda_prev_q <= sda_s;
      end
   end

   assign sda_o       = sda_s;
   assign scl_rise_o  =  scl_s & ~scl_prev_q;
   assign scl_fall_o  = ~scl_s &  scl_prev_q;
   // SDA may only move with SCL high for START/STOP, so require SCL high on both samples.
   assign start_det_o =  scl_s &  scl_prev_q &  sda_prev_q & ~sda_s;
   assign stop_det_o  =  scl_s &  scl_prev_q & ~sda_prev_q &  sda_s;

endmodule

// File: rtl/i2c_slave_mem.sv
// I2C target with a 256x8 register memory behaving like a 24-series EEPROM:
// byte/page writes, current-address and random reads, sequential reads.
module i2c_slave_mem
   import i2c_slave_mem_pkg::*;
#(
   parameter logic [6:0] DEV_ADDR    = DEV_ADDR_DEF,
   parameter int         MEM_DEPTH   = MEM_DEPTH_DEF,
   parameter int         SYNC_STAGES = SYNC_STAGES_DEF
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       scl_in,
   input  logic       sda_in,
   output logic       sda_oe,
   output logic       busy,
   output logic       wr_strobe,
   output logic [7:0] wr_addr,
   output logic [7:0] wr_data
);

   logic sda_s, scl_rise, scl_fall, start_det, stop_det;

   i2c_slave_mem_bus_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
      .clk        (clk),
      .rst        (rst),
      .scl_i      (scl_in),
      .sda_i      (sda_in),
      .sda_o      (sda_s),
      .scl_rise_o (scl_rise),
      .scl_fall_o (scl_fall),
      .start_det_o(start_det),
      .stop_det_o (stop_det)
   );

   state_e     state_q, state_d;
   ack_phase_e phase_q, phase_d;
   logic [2:0] bit_cnt_q, bit_cnt_d;
   logic [7:0] shift_q, shift_d;
   logic [7:0] ptr_q, ptr_d;
   logic       rw_q, rw_d;
   logic       busy_q, busy_d;
   logic       sda_oe_q, sda_oe_d;
   logic       wr_strobe_q, wr_strobe_d;
   logic [7:0] wr_addr_q, wr_addr_d;
   logic [7:0] wr_data_q, wr_data_d;
   logic [7:0] byte_in;
   logic [7:0] rd_q;
   logic [7:0] mem [MEM_DEPTH];

   assign byte_in = {shift_q[6:0], sda_s};

   // Next-state logic: START/STOP first, then per-state reaction to SCL edges.
   always_comb begin
      state_d     = state_q;
      phase_d     = phase_q;
      bit_cnt_d   = bit_cnt_q;
      shift_d     = shift_q;
      ptr_d       = ptr_q;
      rw_d        = rw_q;
      busy_d      = busy_q;
      sda_oe_d    = sda_oe_q;
      wr_strobe_d = 1'b0;
      wr_addr_d   = wr_addr_q;
      wr_data_d   = wr_data_q;

      if (stop_det) begin
         state_d   = ST_IDLE;
         phase_d   = AP_PRE;
         bit_cnt_d = 3'd0;
         busy_d    = 1'b0;
         sda_oe_d  = 1'b0;
      end else if (start_det) begin
         state_d   = ST_DEV_ADDR;
         phase_d   = AP_PRE;
         bit_cnt_d = 3'd0;
         sda_oe_d  = 1'b0;
      end else begin
         case (state_q)
            ST_DEV_ADDR, ST_WORD_ADDR, ST_WR_DATA: begin
               if (scl_rise) begin
                  shift_d   = byte_in;
                  bit_cnt_d = bit_cnt_q + 3'd1;
                  if (bit_cnt_q == 3'd7) begin
                     phase_d = AP_PRE;
                     if (state_q == ST_DEV_ADDR) begin
                        if (addr_match(byte_in, DEV_ADDR)) begin
                           state_d = ST_DEV_ACK;
                           busy_d  = 1'b1;
                           rw_d    = byte_in[RW_BIT];
                        end else begin
                           state_d = ST_IDLE;
                        end
                     end else if (state_q == ST_WORD_ADDR) begin
                        state_d = ST_WORD_ACK;
                        ptr_d   = byte_in;
                     end else begin
                        // Full data byte: commit now, before the ACK clock.
                        state_d     = ST_WR_ACK;
                        wr_strobe_d = 1'b1;
                        wr_addr_d   = ptr_q;
                        wr_data_d   = byte_in;
                        ptr_d       = ptr_q + 8'd1;
                     end
                  end
               end
            end
            ST_DEV_ACK, ST_WORD_ACK, ST_WR_ACK: begin
               if (scl_fall) begin
                  if (phase_q == AP_PRE) begin
                     sda_oe_d = 1'b1;
                     phase_d  = AP_MID;
                  end else begin
                     phase_d   = AP_PRE;
                     bit_cnt_d = 3'd0;
                     if (state_q == ST_DEV_ACK && rw_q) begin
                        state_d  = ST_READ_DATA;
                        shift_d  = rd_q;
                        sda_oe_d = ~rd_q[7];
                     end else begin
                        sda_oe_d = 1'b0;
                        state_d  = (state_q == ST_DEV_ACK) ? ST_WORD_ADDR : ST_WR_DATA;
                     end
                  end
               end
            end
            ST_READ_DATA: begin
               if (scl_rise) begin
                  bit_cnt_d = bit_cnt_q + 3'd1;
                  if (bit_cnt_q == 3'd7) begin
                     state_d = ST_READ_ACK;
                     phase_d = AP_PRE;
                  end
               end else if (scl_fall) begin
                  shift_d  = {shift_q[6:0], 1'b0};
                  sda_oe_d = ~shift_q[6];
               end
            end
            ST_READ_ACK: begin
               if (phase_q == AP_PRE && scl_fall) begin
                  sda_oe_d = 1'b0;
                  phase_d  = AP_MID;
               end else if (phase_q == AP_MID && scl_rise) begin
                  if (sda_s == I2C_NACK) begin
                     state_d = ST_IDLE;
                     phase_d = AP_PRE;
                  end else begin
                     ptr_d   = ptr_q + 8'd1;
                     phase_d = AP_POST;
                  end
               end else if (phase_q == AP_POST && scl_fall) begin
                  state_d   = ST_READ_DATA;
                  phase_d   = AP_PRE;
                  bit_cnt_d = 3'd0;
                  shift_d   = rd_q;
                  sda_oe_d  = ~rd_q[7];
               end
            end
            default: ;
         endcase
      end
   end

   // Control and output registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         phase_q     <= AP_PRE;
         bit_cnt_q   <= 3'd0;
         shift_q     <= 8'd0;
         ptr_q       <= 8'd0;
         rw_q        <= 1'b0;
         busy_q      <= 1'b0;
         sda_oe_q    <= 1'b0;
         wr_strobe_q <= 1'b0;
         wr_addr_q   <= 8'd0;
         wr_data_q   <= 8'd0;
      end else begin
         state_q     <= state_d;
         phase_q     <= phase_d;
         bit_cnt_q   <= bit_cnt_d;
         shift_q     <= shift_d;
         ptr_q       <= ptr_d;
         rw_q        <= rw_d;
         busy_q      <= busy_d;
         sda_oe_q    <= sda_oe_d;
         wr_strobe_q <= wr_strobe_d;
         wr_addr_q   <= wr_addr_d;
         wr_data_q   <= wr_data_d;
      end
   end

   // Memory: written alongside the strobe register, read every cycle at the pointer
   // so the byte is ready long before the SCL fall that loads it. Contents survive reset.
   always_ff @(posedge clk) begin
      if (wr_strobe_d && !rst) begin
         mem[wr_addr_d] <= wr_data_d;
      end
      rd_q <= mem[ptr_q];
   end

   // Reset releases SDA immediately rather than waiting for the register to clear.
   assign sda_oe    = sda_oe_q & ~rst;
   assign busy      = busy_q;
   assign wr_strobe = wr_strobe_q;
   assign wr_addr   = wr_addr_q;
   assign wr_data   = wr_data_q;

endmodule

// File: tb/tb_i2c_slave_mem.sv
// Bench for i2c_slave_mem: bit-level I2C initiator with an open-drain SDA line,
// byte-array reference memory and a strobe log.
module tb_i2c_slave_mem;

   localparam int         Q   = 8;       // clk cycles per quarter SCL period
   localparam logic [6:0] DEV = 7'h50;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       scl_m = 1'b1;
   logic       sda_m = 1'b1;
   logic       sda_line;
   logic       sda_oe, busy, wr_strobe;
   logic [7:0] wr_addr, wr_data;

   int vec_cnt = 0;
   int err_cnt = 0;

   logic [7:0]  mem_m   [256];
   bit          known_m [256];
   logic [7:0]  ptr_m = 8'd0;
   logic [7:0]  buf_m   [4];
   logic [15:0] strobe_log [$];
   logic        oe_prev = 1'b0;

   assign sda_line = sda_m & ~sda_oe;

   i2c_slave_mem dut (
      .clk      (clk),
      .rst      (rst),
      .scl_in   (scl_m),
      .sda_in   (sda_line),
      .sda_oe   (sda_oe),
      .busy     (busy),
      .wr_strobe(wr_strobe),
      .wr_addr  (wr_addr),
      .wr_data  (wr_data)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vec_cnt++;
      if (got !== exp) begin
         err_cnt++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   // Log write strobes; every SDA drive change must land while SCL is low.
   always @(negedge clk) begin
      if (wr_strobe === 1'b1) strobe_log.push_back({wr_addr, wr_data});
      if (sda_oe !== oe_prev) check_eq("oe_change_scl_low", 32'(scl_m), 32'd0);
      oe_prev = sda_oe;
   end

   task automatic wait_q();
      repeat (Q) @(posedge clk);
      #1;
   endtask

   task automatic bus_start();
      sda_m = 1'b1; wait_q();
      scl_m = 1'b1; wait_q();
      sda_m = 1'b0; wait_q();
      scl_m = 1'b0; wait_q();
   endtask

   task automatic bus_stop();
      sda_m = 1'b0; wait_q();
      scl_m = 1'b1; wait_q();
      sda_m = 1'b1; wait_q();
   endtask

   task automatic bit_xfer(input logic b, output logic s);
      sda_m = b;    wait_q();
      scl_m = 1'b1; wait_q();
      s = sda_line; wait_q();
      scl_m = 1'b0; wait_q();
   endtask

   task automatic send_byte(input logic [7:0] b, output logic ack_line);
      logic s;
      for (int i = 7; i >= 0; i--) bit_xfer(b[i], s);
      bit_xfer(1'b1, ack_line);
   endtask

   task automatic recv_byte(input logic nack, output logic [7:0] d);
      logic s;
      for (int i = 7; i >= 0; i--) begin
         bit_xfer(1'b1, s);
         d[i] = s;
      end
      bit_xfer(nack, s);
   endtask

   task automatic do_write(input logic [7:0] start, input int n);
      logic a;
      logic [7:0] ea;
      strobe_log.delete();
      bus_start();
      send_byte({DEV, 1'b0}, a); check_eq("wr_dev_ack", 32'(a), 32'd0);
      check_eq("busy_in_txn", 32'(busy), 32'd1);
      send_byte(start, a);       check_eq("wr_word_ack", 32'(a), 32'd0);
      for (int i = 0; i < n; i++) begin
         send_byte(buf_m[i], a); check_eq("wr_data_ack", 32'(a), 32'd0);
      end
      bus_stop();
      repeat (4) @(posedge clk); #1;
      check_eq("busy_after_stop", 32'(busy), 32'd0);
      check_eq("strobe_count", 32'(strobe_log.size()), 32'(n));
      for (int i = 0; i < n; i++) begin
         ea = start + 8'(i);
         if (i < strobe_log.size())
            check_eq("strobe_addr_data", 32'(strobe_log[i]), 32'({ea, buf_m[i]}));
         mem_m[ea]   = buf_m[i];
         known_m[ea] = 1'b1;
      end
      ptr_m = start + 8'(n);
      $display("write  start=%02h n=%0d first=%02h", start, n, buf_m[0]);
   endtask

   task automatic do_read(input logic [7:0] start, input int n);
      logic a;
      logic [7:0] d, ea;
      strobe_log.delete();
      bus_start();
      send_byte({DEV, 1'b0}, a); check_eq("rd_dev_ack", 32'(a), 32'd0);
      send_byte(start, a);       check_eq("rd_word_ack", 32'(a), 32'd0);
      bus_start();
      send_byte({DEV, 1'b1}, a); check_eq("rd_dev_ack_r", 32'(a), 32'd0);
      for (int i = 0; i < n; i++) begin
         recv_byte(i == n - 1, d);
         ea = start + 8'(i);
         if (known_m[ea]) check_eq("rd_data", 32'(d), 32'(mem_m[ea]));
      end
      check_eq("sda_rel_nack", 32'(sda_oe), 32'd0);
      bus_stop();
      check_eq("no_strobe_rd", 32'(strobe_log.size()), 32'd0);
      // Only ACKed bytes advance the pointer; the NACKed last byte does not.
      ptr_m = start + 8'(n - 1);
      $display("read   start=%02h n=%0d", start, n);
   endtask

   task automatic do_cur_read();
      logic a;
      logic [7:0] d;
      bus_start();
      send_byte({DEV, 1'b1}, a); check_eq("cur_dev_ack", 32'(a), 32'd0);
      recv_byte(1'b1, d);
      check_eq("cur_rd_data", 32'(d), 32'(mem_m[ptr_m]));
      bus_stop();
      $display("curread ptr=%02h data=%02h", ptr_m, d);
   endtask

   initial begin
      repeat (95000) @(posedge clk);
      $display("FAIL watchdog: got no finish, expected finish within cycle budget");
      $fatal(1, "cycle budget exhausted");
   end

   initial begin
      logic       a, s;
      logic [7:0] st;
      int         n;

      for (int i = 0; i < 256; i++) known_m[i] = 1'b0;

      repeat (5) @(posedge clk); #1;
      rst = 1'b0;
      repeat (2) @(posedge clk); #1;
      check_eq("rst_sda_oe",    32'(sda_oe),    32'd0);
      check_eq("rst_busy",      32'(busy),      32'd0);
      check_eq("rst_wr_strobe", 32'(wr_strobe), 32'd0);
      check_eq("rst_wr_addr",   32'(wr_addr),   32'd0);
      check_eq("rst_wr_data",   32'(wr_data),   32'd0);
      $display("reset  done");

      // Byte write then random read back.
      buf_m[0] = 8'hAA;
      do_write(8'h55, 1);
      do_read(8'h55, 1);

      // Sequential write across the top of memory, read back, then current-address read.
      buf_m[0] = 8'h01; buf_m[1] = 8'h02; buf_m[2] = 8'h03;
      do_write(8'hFE, 3);
      do_read(8'hFE, 3);
      do_cur_read();

      // Wrong device address is ignored.
      strobe_log.delete();
      bus_start();
      send_byte(8'hA2, a);
      check_eq("wrong_dev_nack", 32'(a), 32'd1);
      check_eq("wrong_dev_busy", 32'(busy), 32'd0);
      bus_stop();
      check_eq("wrong_dev_strobe", 32'(strobe_log.size()), 32'd0);
      $display("wrongdev addr=a2");

      // STOP after four data bits discards the partial byte.
      buf_m[0] = 8'h00;
      do_write(8'h10, 1);
      strobe_log.delete();
      bus_start();
      send_byte({DEV, 1'b0}, a); check_eq("part_dev_ack", 32'(a), 32'd0);
      send_byte(8'h10, a);       check_eq("part_word_ack", 32'(a), 32'd0);
      for (int i = 0; i < 4; i++) bit_xfer(1'b1, s);
      bus_stop();
      repeat (4) @(posedge clk); #1;
      check_eq("part_no_strobe", 32'(strobe_log.size()), 32'd0);
      $display("partial stop after 4 bits");
      do_read(8'h10, 1);

      // Reset in the middle of a read while the target is pulling SDA low.
      bus_start();
      send_byte({DEV, 1'b0}, a);
      send_byte(8'h10, a);
      bus_start();
      send_byte({DEV, 1'b1}, a); check_eq("mid_dev_ack", 32'(a), 32'd0);
      for (int i = 0; i < 3; i++) bit_xfer(1'b1, s);
      check_eq("mid_oe_driving", 32'(sda_oe), 32'd1);
      @(posedge clk); #1;
      rst = 1'b1;
      #1;
      check_eq("mid_oe_rst_now", 32'(sda_oe), 32'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      check_eq("mid_oe_after_rst", 32'(sda_oe), 32'd0);
      check_eq("mid_busy_after_rst", 32'(busy), 32'd0);
      ptr_m = 8'd0;
      bus_stop();
      $display("reset  mid-read");
      do_read(8'h10, 1);

      // Randomised write/read-back rounds.
      for (int r = 0; r < 6; r++) begin
         st = 8'($urandom_range(0, 255));
         n  = $urandom_range(1, 4);
         for (int i = 0; i < 4; i++) buf_m[i] = 8'($urandom);
         do_write(st, n);
         do_read(st, n);
         if (known_m[ptr_m]) do_cur_read();
      end

      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
      $finish;
   end

endmodule
